// File: rtl/alu_result_checker.sv
// alu_result_checker: snoops ALU operand issues, queues golden {flag,result} and
// compares each DUT result beat in order, keeping counters, sticky errors and a snapshot.
module alu_result_checker #(
    parameter int width     = 8,
    parameter int op_width  = 3,
    parameter int res_width = 20,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 in_valid,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    input  logic [op_width-1:0]  op,
    input  logic                 mode,
    input  logic                 res_valid,
    input  logic [res_width-1:0] result,
    input  logic                 flag,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 err_ovf,
    output logic                 err_unf,
    output logic                 mismatch,
    output logic [res_width:0]   snap_exp,
    output logic [res_width:0]   snap_got,
    output logic                 done
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = res_width + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     mem_q [DEPTH];
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;
    logic [RW-1:0]     sexp_q, sexp_d, sgot_q, sgot_d;

    logic [res_width-1:0] a_x, b_x, exp_res;
    logic [RW-1:0]        exp_entry, head, got;
    logic empty, full, start_go, push_req, beat, pop, unf, push, ovf, ok, bad;

    assign a_x = {{(res_width-width){mode & a[width-1]}}, a};
    assign b_x = {{(res_width-width){mode & b[width-1]}}, b};

    always_comb begin
        exp_res = '0;
        case (op)
            3'd0: exp_res = a_x + b_x;
            3'd1: exp_res = a_x - b_x;
            3'd2: exp_res = a_x & b_x;
            3'd3: exp_res = a_x | b_x;
            3'd4: exp_res = a_x ^ b_x;
            3'd5: exp_res = a_x * b_x;
            3'd6: exp_res = a_x;
            default: exp_res = b_x;
        endcase
    end

    assign exp_entry = {exp_res == '0, exp_res};
    assign empty     = wr_q == rd_q;
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head      = mem_q[rd_q[AW-1:0]];
    assign got       = {flag, result};
    assign start_go  = start && (state_q == IDLE || state_q == DONE);
    assign push_req  = in_valid && state_q == RUN;
    assign beat      = res_valid && (state_q == RUN || state_q == DRAIN);
    assign unf       = beat && empty;
    assign pop       = beat && !empty;
    // At full, a same-cycle pop frees the slot the push needs.
    assign push      = push_req && (!full || pop);
    assign ovf       = push_req && full && !pop;
    assign ok        = pop && head == got;
    assign bad       = (pop && head != got) || unf;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = stop ? DRAIN : RUN;
            DRAIN:   state_d = (empty && !res_valid) ? DONE : DRAIN;
            default: state_d = start ? RUN : DONE;
        endcase
    end

    always_comb begin
        wr_d   = start_go ? '0 : wr_q + (AW+1)'(push);
        rd_d   = start_go ? '0 : rd_q + (AW+1)'(pop);
        pass_d = start_go ? '0 : pass_q + CNT_W'(ok && pass_q != '1);
        fail_d = start_go ? '0 : fail_q + CNT_W'(bad && fail_q != '1);
        ovf_d  = !start_go && (ovf_q || ovf);
        unf_d  = !start_go && (unf_q || unf);
        mis_d  = !start_go && (mis_q || bad);
        sexp_d = start_go ? '0 : (bad && !mis_q) ? (unf ? '0 : head) : sexp_q;
        sgot_d = start_go ? '0 : (bad && !mis_q) ? got : sgot_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            mis_q   <= 1'b0;
            sexp_q  <= '0;
            sgot_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            mis_q   <= mis_d;
            sexp_q  <= sexp_d;
            sgot_q  <= sgot_d;
            if (push) mem_q[wr_q[AW-1:0]] <= exp_entry;
        end
    end

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err_ovf  = ovf_q;
    assign err_unf  = unf_q;
    assign mismatch = mis_q;
    assign snap_exp = sexp_q;
    assign snap_got = sgot_q;
    assign done     = state_q == DONE;
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed vectors with hand-computed golden values.
module tb_alu_result_checker;
    localparam int DEPTH = 8;

    logic        clk = 0, rstn = 0, start = 0, stop = 0;
    logic        in_valid = 0, mode = 0, res_valid = 0, flag = 0;
    logic [7:0]  a = 0, b = 0;
    logic [2:0]  op = 0;
    logic [19:0] result = 0;
    logic [15:0] pass_cnt, fail_cnt;
    logic        err_ovf, err_unf, mismatch, done;
    logic [20:0] snap_exp, snap_got;
    int          errors = 0, checks = 0;

    alu_result_checker #(.width(8), .op_width(3), .res_width(20), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .op(op), .mode(mode), .res_valid(res_valid), .result(result),
        .flag(flag), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_ovf(err_ovf),
        .err_unf(err_unf), .mismatch(mismatch), .snap_exp(snap_exp), .snap_got(snap_got),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] iop, input logic im, input logic rv,
                         input logic [19:0] r, input logic f);
        in_valid = iv; a = ia; b = ib; op = iop; mode = im;
        res_valid = rv; result = r; flag = f;
        tick();
        in_valid = 0; res_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic finish_run(input string tag);
        stop = 1; tick(); stop = 0;
        for (int i = 0; i < 20 && !done; i++) tick();
        chk(tag, done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pass"}, pass_cnt, 0);
        chk({tag, "_fail"}, fail_cnt, 0);
        chk({tag, "_flags"}, {err_ovf, err_unf, mismatch, done}, 0);
        chk({tag, "_snap"}, {snap_exp, snap_got}, 0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        rstn = 1;
        tick();

        // 1: four adds 200+100=300, results lag two cycles
        pulse_start();
        chk("t1_run_not_done", done, 0);
        for (int i = 0; i < 6; i++)
            drive(i < 4, 8'd200, 8'd100, 3'd0, 1'b0, i >= 2, 20'd300, 1'b0);
        finish_run("t1_done");
        chk("t1_pass", pass_cnt, 4);
        chk("t1_fail", fail_cnt, 0);
        chk("t1_mis", mismatch, 0);

        // 2: signed 5-7 = FFFFE, DUT returns 000FE
        pulse_start();
        chk("t2_cleared", pass_cnt, 0);
        drive(1, 8'h05, 8'h07, 3'd1, 1'b1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 20'h000FE, 1'b0);
        chk("t2_fail", fail_cnt, 1);
        chk("t2_mis", mismatch, 1);
        chk("t2_snap_exp", snap_exp, 21'h0FFFFE);
        chk("t2_snap_got", snap_got, 21'h0000FE);
        chk("t2_unf", err_unf, 0);

        // 3: DEPTH+1 pushes, ninth dropped; drain DEPTH good results
        for (int i = 0; i <= DEPTH; i++) drive(1, 8'(i), 8'd1, 3'd0, 1'b0, 0, 0, 0);
        chk("t3_ovf", err_ovf, 1);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 0, 1, 20'(i + 1), 1'b0);
        chk("t3_pass", pass_cnt, DEPTH);
        chk("t3_fail", fail_cnt, 1);
        finish_run("t3_done");

        // 4: underflow, then push+pop at full
        pulse_start();
        chk("t4_ovf_cleared", err_ovf, 0);
        drive(0, 0, 0, 0, 0, 1, 20'h5, 1'b1);
        chk("t4_unf", err_unf, 1);
        chk("t4_fail", fail_cnt, 1);
        chk("t4_snap_exp", snap_exp, 0);
        chk("t4_snap_got", snap_got, 21'h100005);
        for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 8'd0, 3'd0, 1'b0, 0, 0, 0);
        drive(1, 8'd9, 8'd0, 3'd0, 1'b0, 1, 20'd0, 1'b1);
        chk("t4_no_ovf", err_ovf, 0);
        for (int i = 1; i < DEPTH; i++) drive(0, 0, 0, 0, 0, 1, 20'(i), 1'b0);
        drive(0, 0, 0, 0, 0, 1, 20'd9, 1'b0);
        chk("t4_pass", pass_cnt, DEPTH + 1);
        chk("t4_fail_hold", fail_cnt, 1);
        finish_run("t4_done");

        // 5: 255*255, xor to zero, signed -1*2
        pulse_start();
        drive(1, 8'hFF, 8'hFF, 3'd5, 1'b0, 0, 0, 0);
        drive(1, 8'h3C, 8'h3C, 3'd4, 1'b0, 1, 20'h0FE01, 1'b0);
        drive(1, 8'hFF, 8'h02, 3'd5, 1'b1, 1, 20'h00000, 1'b1);
        drive(0, 0, 0, 0, 0, 1, 20'hFFFFE, 1'b0);
        chk("t5_pass", pass_cnt, 3);
        chk("t5_fail", fail_cnt, 0);
        chk("t5_mis", mismatch, 0);
        finish_run("t5_done");

        // 6: async reset mid-RUN with three entries queued
        pulse_start();
        drive(1, 8'd1, 8'd1, 3'd7, 1'b0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 20'd1, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 20'd7, 1'b0);
        for (int i = 0; i < 3; i++) drive(1, 8'd1, 8'd2, 3'd0, 1'b0, 0, 0, 0);
        chk("t6_pre_pass", pass_cnt, 1);
        rstn = 0;
        #2;
        check_all_zero("t6_reset");
        tick();
        rstn = 1;
        tick();
        drive(0, 0, 0, 0, 0, 1, 20'd3, 1'b0);
        chk("t6_idle_ignored", fail_cnt, 0);
        pulse_start();
        drive(1, 8'hF0, 8'h3C, 3'd2, 1'b0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 20'h30, 1'b0);
        finish_run("t6_done");
        chk("t6_pass", pass_cnt, 1);
        chk("t6_fail", fail_cnt, 0);
        chk("t6_flags", {err_ovf, err_unf, mismatch}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
